// File: rtl/fht_io_pkg.sv
// fht_io_pkg
//   Shared definitions for the FHT host-side I/O block.
//   - FHT_* constants: bank address width, sample index width, sample width,
//     transform length and bank count for the 1024-point, 4-bank transform.
//   - state_t: I/O sequencer states (LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD).
//   - bit_rev(): reverses a sample index over FHT_N_BIT bits.
package fht_io_pkg;

   localparam int FHT_A_BIT = 8;
   localparam int FHT_N_BIT = 10;
   localparam int FHT_D_BIT = 16;
   localparam int FHT_N     = 1 << FHT_N_BIT;
   localparam int FHT_BANKS = 4;

   typedef enum logic [2:0] {
      ST_LOAD      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_UNLOAD    = 3'd4
   } state_t;

   function automatic logic [FHT_N_BIT-1:0] bit_rev(input logic [FHT_N_BIT-1:0] n);
      logic [FHT_N_BIT-1:0] r;
      for (int i = 0; i < FHT_N_BIT; i++) begin
         r[i] = n[FHT_N_BIT-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fht_io_fifo2.sv
// fht_io_fifo2
//   Two-entry first-word-fall-through FIFO used as the result skid buffer.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push, din  : write request and word (ignored when full without a pop)
//     pop        : read request (ignored when empty)
//     dout       : head word, valid while empty = 0
//     count      : occupancy 0..2
//     empty      : no word held
//   A push and a pop in the same cycle while full is accepted; count stays 2.
module fht_io_fifo2 #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count,
   output logic         empty
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         push_ok;
   logic         pop_ok;

   assign empty   = (count == 2'd0);
   assign pop_ok  = pop & ~empty;
   // When full, the slot being written is the head being popped this cycle.
   assign push_ok = push & ((count != 2'd2) | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/fht_io_control.sv
// fht_io_control
//   Host-side companion to the FHT controller. Loads N samples from an input
//   stream into 4 banks in bit-reversed order, starts the controller, waits
//   for it to finish, then reads the N results back in natural order onto an
//   output stream buffered by a 2-entry FIFO.
//   Ports:
//     iCLK, iRESET             : clock, asynchronous active-low reset
//     iDATA_IN/iVALID_IN/oREADY_IN : input sample stream (ready only in LOAD)
//     oDATA_OUT/oVALID_OUT/iREADY_OUT/oLAST_OUT : result stream, last on N-1
//     iFHT_RDY, oFHT_START     : controller ready level, one-cycle start pulse
//     oRAM_OWN                 : 1 while this block drives the bank ports
//     oADDR_WR/oDATA_WR/oWE    : registered bank write port, one-hot enable
//     oADDR_RD, iDATA_RD_0..3  : shared read address, per-bank read data
//                                (1-cycle registered RAM latency)
//     oBUSY                    : high outside LOAD
module fht_io_control
   import fht_io_pkg::*;
#(
   parameter int A_BIT = FHT_A_BIT,
   parameter int N_BIT = FHT_N_BIT,
   parameter int D_BIT = FHT_D_BIT
) (
   input  logic                 iCLK,
   input  logic                 iRESET,
   input  logic [D_BIT-1:0]     iDATA_IN,
   input  logic                 iVALID_IN,
   output logic                 oREADY_IN,
   output logic [D_BIT-1:0]     oDATA_OUT,
   output logic                 oVALID_OUT,
   input  logic                 iREADY_OUT,
   output logic                 oLAST_OUT,
   input  logic                 iFHT_RDY,
   output logic                 oFHT_START,
   output logic                 oRAM_OWN,
   output logic [A_BIT-1:0]     oADDR_WR,
   output logic [D_BIT-1:0]     oDATA_WR,
   output logic [FHT_BANKS-1:0] oWE,
   output logic [A_BIT-1:0]     oADDR_RD,
   input  logic [D_BIT-1:0]     iDATA_RD_0,
   input  logic [D_BIT-1:0]     iDATA_RD_1,
   input  logic [D_BIT-1:0]     iDATA_RD_2,
   input  logic [D_BIT-1:0]     iDATA_RD_3,
   output logic                 oBUSY
);

   localparam logic [N_BIT-1:0] LAST_IDX = N_BIT'(FHT_N - 1);

   state_t           state;
   logic [N_BIT-1:0] wr_cnt;
   logic [N_BIT-1:0] rd_cnt;
   logic [N_BIT-1:0] out_cnt;
   logic             rd_done;
   logic             vld_p1;
   logic [1:0]       bank_p1;
   logic             last_p1;
   logic             hs_in;
   logic             pop;
   logic             issue;
   logic [N_BIT-1:0] rev;
   logic [2:0]       occ;
   logic [D_BIT-1:0] rd_word;
   logic [D_BIT:0]   fifo_dout;
   logic [1:0]       fifo_count;
   logic             fifo_empty;

   assign oREADY_IN = (state == ST_LOAD);
   assign oBUSY     = (state != ST_LOAD);
   assign oRAM_OWN  = (state == ST_LOAD) || (state == ST_UNLOAD);
   assign hs_in     = iVALID_IN & oREADY_IN;
   assign rev       = bit_rev(wr_cnt);

   // The read address comes straight from the counter so the registered RAM
   // returns data the cycle after the issue decision.
   assign oADDR_RD  = rd_cnt[N_BIT-1:2];

   assign oVALID_OUT = ~fifo_empty;
   assign oDATA_OUT  = fifo_dout[D_BIT-1:0];
   assign oLAST_OUT  = fifo_dout[D_BIT] & ~fifo_empty;
   assign pop        = oVALID_OUT & iREADY_OUT;

   // Occupancy counts the word still in flight from the RAM so the FIFO can
   // never be pushed past two entries, while a same-cycle pop frees a slot.
   assign occ   = {1'b0, fifo_count} + {2'b00, vld_p1};
   assign issue = (state == ST_UNLOAD) && !rd_done && (occ < (3'd2 + {2'b00, pop}));

   always_comb begin
      rd_word = iDATA_RD_0;
      unique case (bank_p1)
         2'd0:    rd_word = iDATA_RD_0;
         2'd1:    rd_word = iDATA_RD_1;
         2'd2:    rd_word = iDATA_RD_2;
         default: rd_word = iDATA_RD_3;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state      <= ST_LOAD;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         out_cnt    <= '0;
         rd_done    <= 1'b0;
         vld_p1     <= 1'b0;
         bank_p1    <= 2'd0;
         last_p1    <= 1'b0;
         oFHT_START <= 1'b0;
         oWE        <= '0;
         oADDR_WR   <= '0;
         oDATA_WR   <= '0;
      end else begin
         oFHT_START <= 1'b0;
         oWE        <= '0;
         vld_p1     <= 1'b0;

         // write stage: bit-reversed placement, bank from the low reversed bits
         if (hs_in) begin
            oWE      <= FHT_BANKS'(1) << rev[1:0];
            oADDR_WR <= rev[N_BIT-1:2];
            oDATA_WR <= iDATA_IN;
            wr_cnt   <= wr_cnt + 1'b1;
         end

         // read stage p1: remember which bank answers next cycle
         if (issue) begin
            vld_p1  <= 1'b1;
            bank_p1 <= rd_cnt[1:0];
            last_p1 <= (rd_cnt == LAST_IDX);
            rd_cnt  <= rd_cnt + 1'b1;
            if (rd_cnt == LAST_IDX) begin
               rd_done <= 1'b1;
            end
         end

         if (pop) begin
            out_cnt <= out_cnt + 1'b1;
         end

         case (state)
            ST_LOAD: begin
               if (hs_in && (wr_cnt == LAST_IDX)) begin
                  state      <= ST_START;
                  oFHT_START <= 1'b1;
               end
            end
            ST_START: begin
               state <= ST_WAIT_BUSY;
            end
            // Wait for the controller to drop ready first so a level that is
            // still high from before the start cannot skip the transform.
            ST_WAIT_BUSY: begin
               if (!iFHT_RDY) begin
                  state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (iFHT_RDY) begin
                  state <= ST_UNLOAD;
               end
            end
            ST_UNLOAD: begin
               if (pop && (out_cnt == LAST_IDX)) begin
                  state   <= ST_LOAD;
                  rd_done <= 1'b0;
               end
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

   fht_io_fifo2 #(
      .W (D_BIT + 1)
   ) u_fifo (
      .clk   (iCLK),
      .rst_n (iRESET),
      .push  (vld_p1),
      .pop   (pop),
      .din   ({last_p1, rd_word}),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_fht_io_control.sv
module tb_fht_io_control;

   localparam int N = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data_in;
   logic        valid_in;
   logic        ready_in;
   logic [15:0] data_out;
   logic        valid_out;
   logic        ready_out;
   logic        last_out;
   logic        fht_rdy;
   logic        fht_start;
   logic        ram_own;
   logic [7:0]  addr_wr;
   logic [15:0] data_wr;
   logic [3:0]  we;
   logic [7:0]  addr_rd;
   logic        busy;
   logic        fill_req;

   logic [15:0] ram [4][256];
   logic [15:0] rd_q [4];

   typedef struct {
      logic [3:0]  we;
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      int n;
      int bank;
      int addr;
   } map_vec_t;

   wr_t      wq[$];
   int       res_q[$];
   map_vec_t vecs[8];
   int       cap_bank[N];
   int       cap_addr[N];
   bit       ramp_cap;
   int       nchk;
   int       nfail;
   int       wr_count;

   always #5 clk = ~clk;

   fht_io_control dut (
      .iCLK       (clk),
      .iRESET     (rst_n),
      .iDATA_IN   (data_in),
      .iVALID_IN  (valid_in),
      .oREADY_IN  (ready_in),
      .oDATA_OUT  (data_out),
      .oVALID_OUT (valid_out),
      .iREADY_OUT (ready_out),
      .oLAST_OUT  (last_out),
      .iFHT_RDY   (fht_rdy),
      .oFHT_START (fht_start),
      .oRAM_OWN   (ram_own),
      .oADDR_WR   (addr_wr),
      .oDATA_WR   (data_wr),
      .oWE        (we),
      .oADDR_RD   (addr_rd),
      .iDATA_RD_0 (rd_q[0]),
      .iDATA_RD_1 (rd_q[1]),
      .iDATA_RD_2 (rd_q[2]),
      .iDATA_RD_3 (rd_q[3]),
      .oBUSY      (busy)
   );

   // Bank model: registered read, direct write, and a one-cycle fill that
   // stands in for the transform result (word = 4*addr + bank).
   always @(posedge clk) begin
      if (fill_req) begin
         for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 256; a++) begin
               ram[b][a] <= 16'(4 * a + b);
            end
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) ram[b][addr_wr] <= data_wr;
         end
      end
      for (int b = 0; b < 4; b++) begin
         rd_q[b] <= ram[b][addr_rd];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] tb_rev(input int n);
      logic [9:0] v;
      logic [9:0] r;
      v = 10'(n);
      for (int i = 0; i < 10; i++) r[i] = v[9-i];
      return r;
   endfunction

   function automatic int onehot_idx(input logic [3:0] v);
      case (v)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   // Advance to the next falling edge and check any bank write issued by the
   // preceding rising edge against the write scoreboard.
   task automatic tick();
      wr_t e;
      @(negedge clk);
      if (we != 4'b0000) begin
         wr_count++;
         if (ramp_cap) begin
            cap_bank[data_wr[9:0]] = onehot_idx(we);
            cap_addr[data_wr[9:0]] = int'(addr_wr);
         end
         if (wq.size() == 0) begin
            chk("wr_spurious", we, 0);
         end else begin
            e = wq.pop_front();
            chk("wr_we", we, e.we);
            chk("wr_addr", addr_wr, e.addr);
            chk("wr_data", data_wr, e.data);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready_in"}, ready_in, 1);
      chk({tag, "_ram_own"}, ram_own, 1);
      chk({tag, "_start"}, fht_start, 0);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_valid_out"}, valid_out, 0);
      chk({tag, "_last_out"}, last_out, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_addr_wr"}, addr_wr, 0);
      chk({tag, "_addr_rd"}, addr_rd, 0);
      chk({tag, "_data_wr"}, data_wr, 0);
      chk({tag, "_data_out"}, data_out, 0);
   endtask

   task automatic load_frame(input int gap_pct, input bit ramp, input bit pause_last);
      int         cnt;
      int         cyc;
      logic       v;
      logic [9:0] r;
      wr_t        e;
      cnt = 0;
      cyc = 0;
      wr_count = 0;
      while (cnt < N && cyc < 10 * N) begin
         if (pause_last && cnt == N - 1) begin
            valid_in = 1'b0;
            repeat (5) tick();
            chk("no_start_at_1023", fht_start, 0);
            chk("ready_at_1023", ready_in, 1);
            chk("busy_at_1023", busy, 0);
            chk("writes_at_1023", wr_count, N - 1);
            pause_last = 1'b0;
         end
         v = ($urandom_range(99) >= gap_pct);
         valid_in = v;
         data_in  = ramp ? 16'(cnt) : 16'($urandom);
         if (v && ready_in) begin
            r      = tb_rev(cnt);
            e.we   = 4'b0001 << r[1:0];
            e.addr = r[9:2];
            e.data = data_in;
            wq.push_back(e);
            cnt++;
         end
         tick();
         cyc++;
      end
      valid_in = 1'b0;
      if (cnt < N) chk("load_timeout", cnt, N);
      // Now in the cycle after the last handshake.
      chk("start_pulse", fht_start, 1);
      chk("ready_drop", ready_in, 0);
      chk("start_own", ram_own, 0);
      chk("start_busy", busy, 1);
      tick();
      chk("start_single", fht_start, 0);
      chk("write_total", wr_count, N);
      chk("write_queue_empty", wq.size(), 0);
   endtask

   task automatic transform(input int hold_hi, input int busy_len, input bit junk_valid);
      if (junk_valid) valid_in = 1'b1;
      for (int i = 0; i < hold_hi; i++) begin
         data_in = 16'($urandom);
         chk("hold_hi_no_unload", ram_own, 0);
         chk("hold_hi_no_valid", valid_out, 0);
         tick();
      end
      fht_rdy = 1'b0;
      repeat (busy_len) tick();
      chk("busy_no_own", ram_own, 0);
      chk("busy_ready_in", ready_in, 0);
      valid_in = 1'b0;
      fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      for (int i = 0; i < N; i++) res_q.push_back(i);
      fht_rdy = 1'b1;
   endtask

   task automatic unload(input int ready_pct, input int abort_at);
      int   pops;
      int   cyc;
      bit   aborted;
      logic r;
      pops = 0;
      cyc = 0;
      aborted = 1'b0;
      ready_out = 1'b0;
      tick();
      chk("t0_own", ram_own, 1);
      chk("t0_valid", valid_out, 0);
      tick();
      chk("t1_valid", valid_out, 0);
      tick();
      chk("t2_valid", valid_out, 1);
      while (pops < N && cyc < 8 * N) begin
         if (abort_at >= 0 && pops == abort_at) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("abort");
            aborted = 1'b1;
            break;
         end
         r = ($urandom_range(99) < ready_pct);
         ready_out = r;
         if (valid_out) begin
            if (res_q.size() == 0) begin
               chk("out_spurious", valid_out, 0);
            end else begin
               chk("out_data", data_out, res_q[0]);
               chk("out_last", last_out, (res_q[0] == N - 1));
               if (r) begin
                  void'(res_q.pop_front());
                  pops++;
               end
            end
         end else begin
            chk("idle_last", last_out, 0);
         end
         tick();
         cyc++;
      end
      ready_out = 1'b0;
      if (aborted) begin
         res_q.delete();
         wq.delete();
         tick();
         tick();
         rst_n = 1'b1;
         tick();
      end else begin
         if (pops < N) chk("unload_timeout", pops, N);
         chk("end_ready_in", ready_in, 1);
         chk("end_busy", busy, 0);
         chk("end_valid", valid_out, 0);
         chk("end_own", ram_own, 1);
         chk("end_queue_empty", res_q.size(), 0);
      end
   endtask

   initial begin
      nchk = 0;
      nfail = 0;
      wr_count = 0;
      ramp_cap = 1'b0;
      rst_n = 1'b0;
      data_in = '0;
      valid_in = 1'b0;
      ready_out = 1'b0;
      fht_rdy = 1'b1;
      fill_req = 1'b0;
      for (int i = 0; i < N; i++) begin
         cap_bank[i] = -1;
         cap_addr[i] = -1;
      end
      vecs = '{'{1, 0, 128}, '{2, 0, 64}, '{3, 0, 192}, '{512, 1, 0},
               '{0, 0, 0}, '{1023, 3, 255}, '{256, 2, 0}, '{4, 0, 32}};

      tick();
      tick();
      check_reset_outputs("por");
      rst_n = 1'b1;
      tick();

      // Frame 1: ramp, no gaps, long transform, no backpressure.
      ramp_cap = 1'b1;
      load_frame(0, 1'b1, 1'b0);
      ramp_cap = 1'b0;
      foreach (vecs[i]) begin
         chk($sformatf("map_bank_n%0d", vecs[i].n), cap_bank[vecs[i].n], vecs[i].bank);
         chk($sformatf("map_addr_n%0d", vecs[i].n), cap_addr[vecs[i].n], vecs[i].addr);
      end
      transform(0, 2590, 1'b0);
      unload(100, -1);

      // Frame 2: input gaps, stall before the last sample, controller ready
      // held high after start, random output backpressure.
      load_frame(40, 1'b0, 1'b1);
      transform(20, 100, 1'b1);
      unload(50, -1);

      // Frame 3: reset in the middle of the unload.
      load_frame(0, 1'b0, 1'b0);
      transform(0, 30, 1'b0);
      unload(50, 300);

      // Frame 4: next frame after the abort starts again from sample 0.
      load_frame(30, 1'b1, 1'b0);
      transform(0, 50, 1'b0);
      unload(100, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/fht_io_control.md
Name: fht_io_control

Overview:
- Host-side companion to the FHT controller for the 1024-point, 4-bank (256 words each) transform.
- Accepts N input samples on a valid/ready stream and writes them into the 4 banks in bit-reversed order.
- Pulses the controller start, waits for controller ready, then reads the N results back in natural order.
- Emits the results on a valid/ready output stream with a 2-entry buffer for backpressure.

Parameters:
- A_BIT, 8, bank address width (256 words per bank).
- N_BIT, 10, sample index width (N = 2^N_BIT = 1024 = 4 banks x 2^A_BIT).
- D_BIT, 16, sample data width.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous active-low reset.
- iDATA_IN  in  D_BIT  input sample.
- iVALID_IN  in  1  input sample valid.
- oREADY_IN  out  1  block accepts input; high only in LOAD.
- oDATA_OUT  out  D_BIT  result sample.
- oVALID_OUT  out  1  result valid.
- iREADY_OUT  in  1  downstream accepts result.
- oLAST_OUT  out  1  high with result index N-1.
- iFHT_RDY  in  1  controller ready (controller oRDY).
- oFHT_START  out  1  one-cycle start pulse to controller.
- oRAM_OWN  out  1  1 = this block drives bank ports (LOAD/UNLOAD); 0 = controller owns banks.
- oADDR_WR  out  A_BIT  bank write address.
- oDATA_WR  out  D_BIT  bank write data.
- oWE  out  4  per-bank write enable, one-hot or zero.
- oADDR_RD  out  A_BIT  bank read address, common to all 4 banks.
- iDATA_RD_0..iDATA_RD_3  in  D_BIT each  bank read data, 1-cycle registered RAM latency.
- oBUSY  out  1  high in every state except LOAD.

Behaviour:
- Reset values: state = LOAD, all counters 0, FIFO empty.
  - oREADY_IN = 1 and oRAM_OWN = 1 (LOAD outputs).
  - oFHT_START, oWE, oVALID_OUT, oLAST_OUT, oBUSY = 0.
  - oADDR_* and oDATA_* = 0.
- Reset mid-operation aborts immediately to these values. Bank contents are not cleared.
- FSM states: LOAD -> START -> WAIT_BUSY -> WAIT_DONE -> UNLOAD -> LOAD.
- LOAD:
  - oREADY_IN = 1. Each cycle with iVALID_IN & oREADY_IN writes one sample, registered.
  - Sample index n (N_BIT counter, 0..N-1). r = bit-reverse of n over N_BIT bits.
  - Write target: bank = r[1:0], oADDR_WR = r[N_BIT-1:2], oDATA_WR = iDATA_IN, oWE = one-hot(bank).
  - All write outputs are valid the cycle after the handshake.
  - No handshake in a cycle -> oWE = 0.
  - Handshake at n = N-1 -> counter wraps to 0; next state START. oREADY_IN drops the cycle after that handshake.
- START:
  - oFHT_START = 1 for exactly one cycle; oRAM_OWN = 0 from this state on.
  - The final write (issued the cycle after the last handshake) coincides with START and completes while oRAM_OWN is still held in write mode by the registered path. The external mux applies oRAM_OWN one cycle late for writes.
- WAIT_BUSY: stay until iFHT_RDY = 0, then WAIT_DONE.
- WAIT_DONE: stay until iFHT_RDY = 1 (rising level), then UNLOAD.
  - If iFHT_RDY is already 1 on entry to WAIT_BUSY, keep waiting for it to fall. Never skip the transform.
- UNLOAD (oRAM_OWN = 1):
  - Read index k issues bank = k[1:0], oADDR_RD = k[N_BIT-1:2].
  - The bank index is delayed 1 cycle and selects iDATA_RD_x; the selected word is pushed into the FIFO.
  - Issue rule: issue a read when fifo_count + inflight - pop < 2. pop = oVALID_OUT & iREADY_OUT in the same cycle.
  - Throughput: sustains 1 result/cycle with iREADY_OUT held high.
  - Latency: read issued in the first UNLOAD cycle t0; oVALID_OUT = 1 at t0+2.
  - oDATA_OUT and oVALID_OUT are driven from the FIFO head. They stay stable while iREADY_OUT = 0.
  - oLAST_OUT = 1 with the head whose index is N-1.
  - After the pop of index N-1: return to LOAD. Read counter and output counter wrap to 0. FIFO is empty.
- Counter widths: n and k are N_BIT wide; the output counter is N_BIT wide; inflight is 1 bit.
- iVALID_IN is ignored outside LOAD. The input stream stalls via oREADY_IN = 0; no sample is dropped.

Decomposition:
- Package fht_io_pkg holds:
  - state encoding: LOAD = 0, START = 1, WAIT_BUSY = 2, WAIT_DONE = 3, UNLOAD = 4;
  - N and bank-count constants;
  - bit-reverse function over N_BIT.
- Sub-module fht_io_fifo2: 2-entry D_BIT+1 (data+last) FIFO.
  - Ports: push, pop, data in, data out, count[1:0], empty.
  - Simultaneous push and pop while full is allowed; count stays 2.

Test Plan:
- Load ramp 0..1023 with iVALID_IN held high -> 1024 writes, 1 per cycle.
  - n = 1: bank 0, addr 128.
  - n = 2: bank 0, addr 64.
  - n = 3: bank 0, addr 192.
  - n = 512: bank 1, addr 0.
  - Then one oFHT_START pulse.
- Controller model drops iFHT_RDY 1 cycle after start and raises it 2590 cycles later; banks preloaded with word = 4*addr + bank.
  - Expect oDATA_OUT = 0, 1, ..., 1023 in order, oVALID_OUT first high 2 cycles after UNLOAD entry.
  - Expect oLAST_OUT only on 1023, then oREADY_IN = 1.
- Random iREADY_OUT (50%) during UNLOAD -> no duplicated or missing result; data stable while stalled; FIFO never overflows.
- Random iVALID_IN gaps during LOAD -> oWE asserted only for handshaken samples; total 1023 writes is an error, exactly 1024 required before start.
- iFHT_RDY held 1 for 20 cycles after start -> FSM stays in WAIT_BUSY; no UNLOAD until a 1->0->1 sequence.
- Assert iRESET low mid-UNLOAD at k = 300 -> all outputs return to reset values asynchronously; next frame loads from n = 0.
